// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-side partner of the BHT/BTB predictor. Each fetch-stage prediction
// (taken flag, predicted target, PC) travels down the F->D->E pipeline. In
// Execute it is compared with the real branch outcome. The unit produces:
//   - the predictor training strobes,
//   - a flush request with the corrected fetch PC,
//   - saturating statistics counters.
//
// Ports
//   clk            : system clock, rising edge
//   RESET_N        : asynchronous reset, active-low
//   PC_F           : fetch PC
//   PrPCSrc_F      : predicted taken flag for PC_F
//   PrALUResult_F  : predicted target for PC_F
//   StallD         : hold the F->D register
//   FlushD         : invalidate the F->D register
//   FlushE         : invalidate the D->E register
//   Branch_E       : instruction in E is a branch
//   PCSrc_E        : actual taken (condition passed) for the instruction in E
//   ALUResult_E    : actual branch target
//   PC_E           : PC of the instruction in E (predictor update index)
//   PCSrc_Upd_E    : taken value used for predictor training
//   WE_PrPCSrc     : predictor history update strobe
//   WE_PrALUResult : predictor target/tag update strobe
//   Mispredict_E   : flush request; fetch restarts at Redirect_PC_E
//   Redirect_PC_E  : corrected fetch address
//   BrCnt          : resolved-branch count (saturating)
//   MissCnt        : mispredict count (saturating)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 RESET_N,
    input  logic [31:0]          PC_F,
    input  logic                 PrPCSrc_F,
    input  logic [31:0]          PrALUResult_F,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 FlushE,
    input  logic                 Branch_E,
    input  logic                 PCSrc_E,
    input  logic [31:0]          ALUResult_E,
    output logic [31:0]          PC_E,
    output logic                 PCSrc_Upd_E,
    output logic                 WE_PrPCSrc,
    output logic                 WE_PrALUResult,
    output logic                 Mispredict_E,
    output logic [31:0]          Redirect_PC_E,
    output logic [CNT_WIDTH-1:0] BrCnt,
    output logic [CNT_WIDTH-1:0] MissCnt
);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] val,
        input logic                 en
    );
        logic [CNT_WIDTH-1:0] one;
        one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (en && (val != {CNT_WIDTH{1'b1}})) begin
            return val + one;
        end
        return val;
    endfunction

    // F->D register
    logic        valid_d_q, valid_d_d;
    logic [31:0] pc_d_q,    pc_d_d;
    logic        ptk_d_q,   ptk_d_d;
    logic [31:0] ptgt_d_q,  ptgt_d_d;

    // D->E register
    logic        valid_e_q, valid_e_d;
    logic [31:0] pc_e_q,    pc_e_d;
    logic        ptk_e_q,   ptk_e_d;
    logic [31:0] ptgt_e_q,  ptgt_e_d;

    // Statistics
    logic [CNT_WIDTH-1:0] br_cnt_q,   br_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    // Resolution terms
    logic actual_tk;
    logic dir_wrong;
    logic tgt_wrong;
    logic mispredict;

    // Resolution is purely combinational on the E slot and the E inputs.
    // An invalid E slot forces actual_tk and dir_wrong low, which kills
    // every strobe and the flush.
    always_comb begin
        actual_tk  = valid_e_q & Branch_E & PCSrc_E;
        // A non-branch that the predictor called taken (aliasing) is also a
        // direction error, because actual_tk is 0 for it.
        dir_wrong  = valid_e_q & (ptk_e_q != actual_tk);
        tgt_wrong  = actual_tk & ptk_e_q & (ptgt_e_q != ALUResult_E);
        mispredict = dir_wrong | tgt_wrong;
    end

    assign PC_E           = pc_e_q;
    assign PCSrc_Upd_E    = actual_tk;
    assign Mispredict_E   = mispredict;
    assign Redirect_PC_E  = actual_tk ? ALUResult_E : (pc_e_q + 32'd4);
    assign WE_PrPCSrc     = valid_e_q & (Branch_E | ptk_e_q);
    assign WE_PrALUResult = actual_tk & (~ptk_e_q | tgt_wrong);
    assign BrCnt          = br_cnt_q;
    assign MissCnt        = miss_cnt_q;

    // Next-state for both pipeline registers and the counters. A flush only
    // drops the valid bit; the payload is don't-care once invalid.
    always_comb begin
        valid_d_d = valid_d_q;
        pc_d_d    = pc_d_q;
        ptk_d_d   = ptk_d_q;
        ptgt_d_d  = ptgt_d_q;
        if (FlushD || mispredict) begin
            // Flush wins over stall.
            valid_d_d = 1'b0;
        end else if (!StallD) begin
            valid_d_d = 1'b1;
            pc_d_d    = PC_F;
            ptk_d_d   = PrPCSrc_F;
            ptgt_d_d  = PrALUResult_F;
        end

        valid_e_d = valid_d_q;
        pc_e_d    = pc_d_q;
        ptk_e_d   = ptk_d_q;
        ptgt_e_d  = ptgt_d_q;
        if (FlushE || mispredict) begin
            valid_e_d = 1'b0;
            pc_e_d    = pc_e_q;
            ptk_e_d   = ptk_e_q;
            ptgt_e_d  = ptgt_e_q;
        end

        br_cnt_d   = sat_inc(br_cnt_q, valid_e_q & Branch_E);
        miss_cnt_d = sat_inc(miss_cnt_q, mispredict);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_d_q  <= 1'b0;
            pc_d_q     <= '0;
            ptk_d_q    <= 1'b0;
            ptgt_d_q   <= '0;
            valid_e_q  <= 1'b0;
            pc_e_q     <= '0;
            ptk_e_q    <= 1'b0;
            ptgt_e_q   <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_d_q  <= valid_d_d;
            pc_d_q     <= pc_d_d;
            ptk_d_q    <= ptk_d_d;
            ptgt_d_q   <= ptgt_d_d;
            valid_e_q  <= valid_e_d;
            pc_e_q     <= pc_e_d;
            ptk_e_q    <= ptk_e_d;
            ptgt_e_q   <= ptgt_e_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed literal scenarios plus a
// randomized run checked every cycle against a behavioural model.
module tb_branch_resolve_unit;

    localparam int CW     = 4;
    localparam int CNTMAX = 15;

    logic          clk = 1'b0;
    logic          RESET_N;
    logic [31:0]   PC_F, PrALUResult_F, ALUResult_E;
    logic          PrPCSrc_F, StallD, FlushD, FlushE, Branch_E, PCSrc_E;
    logic [31:0]   PC_E, Redirect_PC_E;
    logic          PCSrc_Upd_E, WE_PrPCSrc, WE_PrALUResult, Mispredict_E;
    logic [CW-1:0] BrCnt, MissCnt;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    branch_resolve_unit #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .RESET_N(RESET_N), .PC_F(PC_F), .PrPCSrc_F(PrPCSrc_F),
        .PrALUResult_F(PrALUResult_F), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .Branch_E(Branch_E), .PCSrc_E(PCSrc_E),
        .ALUResult_E(ALUResult_E), .PC_E(PC_E), .PCSrc_Upd_E(PCSrc_Upd_E),
        .WE_PrPCSrc(WE_PrPCSrc), .WE_PrALUResult(WE_PrALUResult),
        .Mispredict_E(Mispredict_E), .Redirect_PC_E(Redirect_PC_E),
        .BrCnt(BrCnt), .MissCnt(MissCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The pipeline is seen as two instruction slots; each slot either holds
    // a prediction record or is empty.
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
    } slot_t;

    slot_t m_d, m_e;
    int    m_br, m_miss;

    function automatic bit taken_of(slot_t e, bit br, bit pcs);
        return e.v && br && pcs;
    endfunction

    function automatic bit miss_of(slot_t e, bit br, bit pcs, logic [31:0] alu);
        bit tk;
        tk = taken_of(e, br, pcs);
        if (!e.v) return 0;
        if (e.tk != tk) return 1;
        return tk && (e.tgt != alu);
    endfunction

    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            m_d = '0; m_e = '0; m_br = 0; m_miss = 0;
        end else begin
            bit    mis;
            slot_t old_d;
            mis   = miss_of(m_e, Branch_E, PCSrc_E, ALUResult_E);
            old_d = m_d;
            if (m_e.v && Branch_E) m_br = (m_br < CNTMAX) ? m_br + 1 : CNTMAX;
            if (mis) m_miss = (m_miss < CNTMAX) ? m_miss + 1 : CNTMAX;
            if (FlushE || mis) m_e.v = 0;
            else m_e = old_d;
            if (FlushD || mis) m_d.v = 0;
            else if (!StallD) m_d = '{v: 1'b1, pc: PC_F, tk: PrPCSrc_F, tgt: PrALUResult_F};
        end
    end

    // Single compare process against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on && RESET_N) begin
            bit tk, mis;
            tk  = taken_of(m_e, Branch_E, PCSrc_E);
            mis = miss_of(m_e, Branch_E, PCSrc_E, ALUResult_E);
            chk("m_PC_E", PC_E, m_e.pc);
            chk("m_Upd", {31'd0, PCSrc_Upd_E}, {31'd0, tk});
            chk("m_Mispredict", {31'd0, Mispredict_E}, {31'd0, mis});
            chk("m_Redirect", Redirect_PC_E, tk ? ALUResult_E : m_e.pc + 32'd4);
            chk("m_WE_PrPCSrc", {31'd0, WE_PrPCSrc}, {31'd0, m_e.v && (Branch_E || m_e.tk)});
            chk("m_WE_PrALU", {31'd0, WE_PrALUResult},
                {31'd0, tk && (!m_e.tk || m_e.tgt != ALUResult_E)});
            chk("m_BrCnt", {28'd0, BrCnt}, m_br);
            chk("m_MissCnt", {28'd0, MissCnt}, m_miss);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input bit br, input bit pcs, input logic [31:0] alu);
        Branch_E = br; PCSrc_E = pcs; ALUResult_E = alu;
    endtask

    // Sends one prediction alone down the pipe, then applies the E inputs
    // for it and stops at the following falling edge.
    task automatic issue(input logic [31:0] pc, input bit ptk, input logic [31:0] ptgt,
                         input bit br, input bit pcs, input logic [31:0] alu);
        cyc();
        PC_F = pc; PrPCSrc_F = ptk; PrALUResult_F = ptgt;
        StallD = 0; FlushD = 0; FlushE = 0;
        set_e(0, 0, 32'h0);
        cyc();
        FlushD = 1;
        cyc();
        set_e(br, pcs, alu);
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_PC_E"}, PC_E, 32'h0);
        chk({tag, "_Redirect"}, Redirect_PC_E, 32'h4);
        chk({tag, "_Mispredict"}, {31'd0, Mispredict_E}, 32'h0);
        chk({tag, "_WE_PrPCSrc"}, {31'd0, WE_PrPCSrc}, 32'h0);
        chk({tag, "_WE_PrALU"}, {31'd0, WE_PrALUResult}, 32'h0);
        chk({tag, "_Upd"}, {31'd0, PCSrc_Upd_E}, 32'h0);
        chk({tag, "_BrCnt"}, {28'd0, BrCnt}, 32'h0);
        chk({tag, "_MissCnt"}, {28'd0, MissCnt}, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RESET_N = 0;
        PC_F = 0; PrPCSrc_F = 0; PrALUResult_F = 0;
        StallD = 0; FlushD = 0; FlushE = 0;
        set_e(0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset_checks("rst");
        @(negedge clk);
        RESET_N = 1;
        chk_on = 1;

        // Correct taken prediction
        issue(32'h100, 1, 32'h200, 1, 1, 32'h200);
        chk("t1_Mispredict", {31'd0, Mispredict_E}, 32'h0);
        chk("t1_WE_PrPCSrc", {31'd0, WE_PrPCSrc}, 32'h1);
        chk("t1_WE_PrALU", {31'd0, WE_PrALUResult}, 32'h0);
        chk("t1_PC_E", PC_E, 32'h100);
        cyc();
        chk("t1_BrCnt", {28'd0, BrCnt}, 32'h1);
        chk("t1_MissCnt", {28'd0, MissCnt}, 32'h0);

        // Missed taken
        issue(32'h104, 0, 32'h0, 1, 1, 32'h300);
        chk("t2_Mispredict", {31'd0, Mispredict_E}, 32'h1);
        chk("t2_Redirect", Redirect_PC_E, 32'h300);
        chk("t2_WE_PrALU", {31'd0, WE_PrALUResult}, 32'h1);
        chk("t2_Upd", {31'd0, PCSrc_Upd_E}, 32'h1);
        cyc();
        @(negedge clk);
        chk("t2_bubble_Upd", {31'd0, PCSrc_Upd_E}, 32'h0);
        chk("t2_bubble_WE", {31'd0, WE_PrPCSrc}, 32'h0);
        chk("t2_BrCnt", {28'd0, BrCnt}, 32'h2);
        chk("t2_MissCnt", {28'd0, MissCnt}, 32'h1);

        // Wrong direction, taken predicted
        issue(32'h108, 1, 32'h400, 1, 0, 32'h0);
        chk("t3_Mispredict", {31'd0, Mispredict_E}, 32'h1);
        chk("t3_Redirect", Redirect_PC_E, 32'h10C);
        chk("t3_WE_PrPCSrc", {31'd0, WE_PrPCSrc}, 32'h1);
        chk("t3_WE_PrALU", {31'd0, WE_PrALUResult}, 32'h0);

        // Target mismatch
        issue(32'h10C, 1, 32'h500, 1, 1, 32'h504);
        chk("t4_Mispredict", {31'd0, Mispredict_E}, 32'h1);
        chk("t4_WE_PrALU", {31'd0, WE_PrALUResult}, 32'h1);
        chk("t4_Redirect", Redirect_PC_E, 32'h504);

        // Aliased non-branch predicted taken
        issue(32'h10, 1, 32'h99, 0, 0, 32'h0);
        chk("t5_Mispredict", {31'd0, Mispredict_E}, 32'h1);
        chk("t5_Redirect", Redirect_PC_E, 32'h14);
        chk("t5_Upd", {31'd0, PCSrc_Upd_E}, 32'h0);
        chk("t5_WE_PrPCSrc", {31'd0, WE_PrPCSrc}, 32'h1);

        // Stall holds D while E sees bubbles
        cyc();
        set_e(1, 1, 32'h0);
        PC_F = 32'h20; PrPCSrc_F = 0; PrALUResult_F = 0;
        StallD = 0; FlushD = 0; FlushE = 0;
        cyc();
        StallD = 1; FlushE = 1; PC_F = 32'h24;
        for (int i = 0; i < 3; i++) begin
            cyc();
            PC_F = PC_F + 32'h4;
            @(negedge clk);
            chk("t6_bubble_WE", {31'd0, WE_PrPCSrc}, 32'h0);
            chk("t6_bubble_Upd", {31'd0, PCSrc_Upd_E}, 32'h0);
        end
        StallD = 0; FlushE = 0; FlushD = 1;
        set_e(0, 0, 32'h0);
        cyc();
        @(negedge clk);
        chk("t6_held_PC_E", PC_E, 32'h20);

        // Flush beats stall
        cyc();
        PC_F = 32'h30; FlushD = 0; StallD = 0; FlushE = 0;
        cyc();
        StallD = 1; FlushD = 1;
        cyc();
        @(negedge clk);
        chk("t7_PC_E", PC_E, 32'h30);
        StallD = 0; FlushD = 0; PC_F = 32'h40;
        set_e(1, 1, 32'h0);
        cyc();
        @(negedge clk);
        chk("t7_flushed_Upd", {31'd0, PCSrc_Upd_E}, 32'h0);
        chk("t7_flushed_WE", {31'd0, WE_PrPCSrc}, 32'h0);

        // Saturation
        for (int i = 0; i < 17; i++) issue(32'h800 + 4 * i, 0, 32'h0, 1, 1, 32'h900);
        cyc();
        chk("sat_BrCnt", {28'd0, BrCnt}, 32'hF);
        chk("sat_MissCnt", {28'd0, MissCnt}, 32'hF);

        // Randomized phase with one asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            cyc();
            if (n == 200) begin
                #2;
                RESET_N = 0;
                #1;
                reset_checks("midrst");
                @(posedge clk);
                #2;
                RESET_N = 1;
            end
            PC_F          = {$urandom_range(0, 32'h3FFF), 2'b00};
            PrPCSrc_F     = $urandom_range(0, 1);
            PrALUResult_F = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 255), 2'b00};
            StallD        = ($urandom_range(0, 7) == 0);
            FlushD        = ($urandom_range(0, 15) == 0);
            FlushE        = ($urandom_range(0, 15) == 0);
            Branch_E      = $urandom_range(0, 1);
            PCSrc_E       = $urandom_range(0, 1);
            ALUResult_E   = $urandom_range(0, 1) ? m_e.tgt : {$urandom_range(0, 255), 2'b00};
        end
        cyc();
        @(negedge clk);
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
